visframe_buffer: RTL

- Downstream consumer of the correlator chain's accumulator output (`vis_*` bus).
- Captures each completed frame of accumulated complex visibilities into a ping-pong pair of banks.
- Streams each committed bank out as an AXI4-Stream packet (one beat per visibility) towards the readout/DMA path.
- Decouples the chain, which cannot stall, from a back-pressured sink: frames that cannot be buffered are dropped whole and flagged.

---
 rtl/visframe_buffer.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/visframe_buffer.sv
// Ping-pong frame buffer: captures accumulated visibility frames and replays each as an AXI4-Stream packet.
// Optional VISFRAME_DROP_COUNT_EN adds a saturating 16-bit dropped-frame counter output.
module visframe_buffer #(
  parameter int unsigned WIDTH = 7,
  parameter int unsigned NVIS  = 3
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               vis_frame_i,
  input  logic               vis_valid_i,
  input  logic               vis_first_i,
  input  logic               vis_last_i,
  input  logic [WIDTH-1:0]   vis_real_i,
  input  logic [WIDTH-1:0]   vis_imag_i,
  output logic               m_tvalid,
  input  logic               m_tready,
  output logic               m_tlast,
  output logic [2*WIDTH-1:0] m_tdata,
  output logic               dropped_o,
  output logic               error_o
`ifdef VISFRAME_DROP_COUNT_EN
  ,
  output logic [15:0]        drop_count_o
`endif
);

  localparam int unsigned ABITS = $clog2(NVIS + 1);
  localparam int unsigned DW    = 2 * WIDTH;
  localparam logic [ABITS-1:0] NVIS_A = ABITS'(NVIS);
  localparam logic [ABITS-1:0] ONE_A  = ABITS'(1);

  typedef enum logic [1:0] {W_IDLE, W_FILL, W_DROP} wstate_t;
  typedef enum logic {R_IDLE, R_SEND} rstate_t;

  wstate_t          wstate_q;
  rstate_t          rstate_q;
  logic             wr_ptr_q;
  logic             rd_ptr_q;
  logic [1:0]       full_q;
  logic [ABITS-1:0] cnt_q;
  logic [ABITS-1:0] rd_idx_q;
  logic [ABITS-1:0] len_q [2];
  logic [DW-1:0]    mem_q [2][NVIS];
  logic             tvalid_q;
  logic             tlast_q;
  logic [DW-1:0]    tdata_q;
  logic             dropped_q;
  logic             error_q;

  logic          accept;
  logic          handshake;
  logic          release_bank;
  logic          load;
  logic [DW-1:0] beat;

  assign accept       = vis_valid_i & vis_frame_i;
  assign beat         = {vis_imag_i, vis_real_i};
  assign handshake    = tvalid_q & m_tready;
  assign release_bank = handshake & tlast_q;
  // Output register reloads only when empty or being consumed, so a stalled beat holds.
  assign load = (rstate_q == R_SEND) && (rd_idx_q != len_q[rd_ptr_q]) && (!tvalid_q || m_tready);

  // Both FSMs share the bank-full flags, so they live in one sequential block.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wstate_q  <= W_IDLE;
      rstate_q  <= R_IDLE;
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
      full_q    <= '0;
      cnt_q     <= '0;
      rd_idx_q  <= '0;
      tvalid_q  <= 1'b0;
      tlast_q   <= 1'b0;
      tdata_q   <= '0;
      dropped_q <= 1'b0;
      error_q   <= 1'b0;
      for (int unsigned i = 0; i < 2; i++) begin
        len_q[i] <= '0;
        for (int unsigned j = 0; j < NVIS; j++) mem_q[i][j] <= '0;
      end
    end else begin
      dropped_q <= 1'b0;

      if (release_bank) begin
        full_q[rd_ptr_q] <= 1'b0;
        rd_ptr_q         <= ~rd_ptr_q;
        rd_idx_q         <= '0;
        rstate_q         <= full_q[~rd_ptr_q] ? R_SEND : R_IDLE;
      end else if (rstate_q == R_IDLE && full_q[rd_ptr_q]) begin
        rstate_q <= R_SEND;
        rd_idx_q <= '0;
      end

      if (load) begin
        tvalid_q <= 1'b1;
        tdata_q  <= mem_q[rd_ptr_q][rd_idx_q];
        tlast_q  <= (rd_idx_q == len_q[rd_ptr_q] - ONE_A);
        rd_idx_q <= rd_idx_q + ONE_A;
      end else if (handshake) begin
        tvalid_q <= 1'b0;
        tlast_q  <= 1'b0;
      end

      if (accept) begin
        unique case (wstate_q)
          W_IDLE: begin
            if (!vis_first_i) begin
              error_q <= 1'b1;
            end else if (full_q[wr_ptr_q]) begin
              if (vis_last_i) dropped_q <= 1'b1;
              else            wstate_q  <= W_DROP;
            end else begin
              mem_q[wr_ptr_q][0] <= beat;
              if (vis_last_i) begin
                full_q[wr_ptr_q] <= 1'b1;
                len_q[wr_ptr_q]  <= ONE_A;
                wr_ptr_q         <= ~wr_ptr_q;
              end else begin
                cnt_q    <= ONE_A;
                wstate_q <= W_FILL;
              end
            end
          end
          W_FILL: begin
            if (vis_first_i) begin
              // Restart in place: the partial frame never left this bank.
              error_q            <= 1'b1;
              mem_q[wr_ptr_q][0] <= beat;
              cnt_q              <= ONE_A;
              if (vis_last_i) begin
                full_q[wr_ptr_q] <= 1'b1;
                len_q[wr_ptr_q]  <= ONE_A;
                wr_ptr_q         <= ~wr_ptr_q;
                wstate_q         <= W_IDLE;
              end
            end else begin
              if (cnt_q < NVIS_A) mem_q[wr_ptr_q][cnt_q] <= beat;
              else                error_q <= 1'b1;
              if (vis_last_i) begin
                full_q[wr_ptr_q] <= 1'b1;
                len_q[wr_ptr_q]  <= (cnt_q < NVIS_A) ? cnt_q + ONE_A : NVIS_A;
                wr_ptr_q         <= ~wr_ptr_q;
                wstate_q         <= W_IDLE;
              end else if (cnt_q < NVIS_A) begin
                cnt_q <= cnt_q + ONE_A;
              end
            end
          end
          W_DROP: begin
            if (vis_last_i) begin
              dropped_q <= 1'b1;
              wstate_q  <= W_IDLE;
            end
          end
          default: wstate_q <= W_IDLE;
        endcase
      end
    end
  end

  assign m_tvalid  = tvalid_q;
  assign m_tlast   = tlast_q;
  assign m_tdata   = tdata_q;
  assign dropped_o = dropped_q;
  assign error_o   = error_q;

`ifdef VISFRAME_DROP_COUNT_EN
  logic [15:0] drop_cnt_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset)                                    drop_cnt_q <= '0;
    else if (dropped_q && drop_cnt_q != 16'hFFFF) drop_cnt_q <= drop_cnt_q + 16'd1;
  end

  assign drop_count_o = drop_cnt_q;
`endif

endmodule
